// File: rtl/w0rm_mem_initiator.sv
// w0rm_mem_initiator
//   Single-outstanding initiator for the W0RM peripheral memory bus. A core
//   request accepted in IDLE is issued onto the bus as a one-cycle strobe.
//   The block then waits for the responder acknowledge, or for the timer to
//   expire, and returns a one-cycle response to the core.
//
// Ports
//   mem_clk, cpu_reset      clock (rising edge), asynchronous active-high reset
//   req_valid_i/ready_o     core request handshake
//   req_write_i/addr/data   request kind, address and store data
//   rsp_valid_o             one-cycle response strobe
//   rsp_data_o/error_o      load data (0 for stores/errors), timeout flag
//   timeout_count_o         saturating count of timed-out transactions
//   mem_valid_o/read/write  bus strobe and its qualifiers
//   mem_addr_o/data_o       latched address and store data
//   mem_valid_i/data_i      responder acknowledge and read data
module w0rm_mem_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  mem_clk,
    input  logic                  cpu_reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_error_o,
    output logic [7:0]            timeout_count_o,
    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] timer;
    logic       write_lat;
    logic       accept;
    logic       ack;
    logic       expire;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reset is folded in so the core never sees ready while reset is held.
    assign req_ready_o = (state == S_IDLE) && !cpu_reset;

    assign accept = (state == S_IDLE) && req_valid_i;
    // An ack in the expiry cycle wins over the timeout.
    assign ack    = (state == S_WAIT) && mem_valid_i;
    assign expire = (state == S_WAIT) && !mem_valid_i && (timer == TMO_LAST);

    always_ff @(posedge mem_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (req_valid_i) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (ack || expire) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Bus strobe and response strobe are registered one edge ahead of the
    // ISSUE and DONE states so they line up exactly with those states.
    always_ff @(posedge mem_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            mem_valid_o     <= 1'b0;
            mem_read_o      <= 1'b0;
            mem_write_o     <= 1'b0;
            mem_addr_o      <= '0;
            mem_data_o      <= '0;
            write_lat       <= 1'b0;
            timer           <= 8'd0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= '0;
            rsp_error_o     <= 1'b0;
            timeout_count_o <= 8'd0;
        end else begin
            mem_valid_o <= accept;
            mem_read_o  <= accept && !req_write_i;
            mem_write_o <= accept && req_write_i;
            rsp_valid_o <= ack || expire;

            if (accept) begin
                mem_addr_o <= req_addr_i;
                mem_data_o <= req_data_i;
                write_lat  <= req_write_i;
                timer      <= 8'd0;
            end else if ((state == S_WAIT) && !ack && !expire) begin
                timer <= timer + 8'd1;
            end

            if (ack) begin
                rsp_data_o  <= write_lat ? '0 : mem_data_i;
                rsp_error_o <= 1'b0;
            end else if (expire) begin
                rsp_data_o      <= '0;
                rsp_error_o     <= 1'b1;
                timeout_count_o <= sat_inc(timeout_count_o);
            end
        end
    end

endmodule

// File: tb/tb_w0rm_mem_initiator.sv
// Testbench for w0rm_mem_initiator: a bus responder model plus a response
// scoreboard. Each request pushes its expected bus strobe and its expected
// response (data, error, arrival cycle, timeout count); the responder and
// the response monitor pop and compare them.
module tb_w0rm_mem_initiator;

    localparam int TMO = 16;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        int          ack;   // WAIT-cycle index of the ack, -1 = never
        logic [31:0] rd;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        logic [7:0]  tc;
    } rsp_t;

    logic        mem_clk;
    logic        cpu_reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [7:0]  timeout_count;
    logic        mem_valid;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        resp_ack;
    logic        stray_ack;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    assign mem_ack = resp_ack | stray_ack;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   rsp_cnt;
    logic [7:0] exp_tc;

    w0rm_mem_initiator #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .mem_clk(mem_clk), .cpu_reset(cpu_reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
        .timeout_count_o(timeout_count),
        .mem_valid_o(mem_valid), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_valid_i(mem_ack), .mem_data_i(mem_rdata)
    );

    initial begin
        mem_clk = 1'b0;
        forever #5 mem_clk = ~mem_clk;
    end

    initial cyc = 0;
    always @(posedge mem_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Responder: checks each strobe against the expected bus entry, checks
    // the strobe is one cycle wide, then acks in the requested WAIT cycle.
    initial begin
        bus_t b;
        resp_ack  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge mem_clk);
            if (mem_valid === 1'b1) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got mem_valid_o=1 at cycle %0d, want no strobe", cyc);
                end else begin
                    b = bus_q.pop_front();
                    checks++;
                    if ({mem_read, mem_write} !== {!b.write, b.write}) begin
                        errors++;
                        $display("FAIL strobe_kind: got read/write=%b%b, want %b%b", mem_read, mem_write, !b.write, b.write);
                    end
                    checks++;
                    if (mem_addr !== b.addr || mem_wdata !== b.data) begin
                        errors++;
                        $display("FAIL strobe_payload: got addr=%h data=%h, want addr=%h data=%h", mem_addr, mem_wdata, b.addr, b.data);
                    end
                    @(negedge mem_clk);
                    checks++;
                    if ({mem_valid, mem_read, mem_write} !== 3'b000) begin
                        errors++;
                        $display("FAIL strobe_width: got valid/read/write=%b%b%b one cycle later, want 000", mem_valid, mem_read, mem_write);
                    end
                    if (b.ack >= 0) begin
                        repeat (b.ack) @(negedge mem_clk);
                        resp_ack  = 1'b1;
                        mem_rdata = b.rd;
                        @(negedge mem_clk);
                        resp_ack  = 1'b0;
                        mem_rdata = 32'hDEAD_BEEF;
                    end
                end
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge mem_clk);
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid_o=1 at cycle %0d, want no response", cyc);
                end else begin
                    r = rsp_q.pop_front();
                    checks++;
                    if (cyc !== r.cyc) begin
                        errors++;
                        $display("FAIL rsp_cycle: got response at cycle %0d, want cycle %0d", cyc, r.cyc);
                    end
                    checks++;
                    if (rsp_data !== r.data || rsp_error !== r.err) begin
                        errors++;
                        $display("FAIL rsp_payload: got data=%h err=%b, want data=%h err=%b", rsp_data, rsp_error, r.data, r.err);
                    end
                    checks++;
                    if (timeout_count !== r.tc) begin
                        errors++;
                        $display("FAIL timeout_count: got %0d, want %0d", timeout_count, r.tc);
                    end
                end
            end
        end
    end

    // Push the expected bus strobe and response for a request accepted at
    // cycle acc.
    task automatic expect_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                              input int ack, input logic [31:0] rd, input int acc);
        bus_t b;
        rsp_t r;
        b.write = wr; b.addr = addr; b.data = wd; b.ack = ack; b.rd = rd;
        bus_q.push_back(b);
        r.err  = (ack < 0);
        r.data = (r.err || wr) ? 32'h0 : rd;
        r.cyc  = r.err ? acc + TMO + 1 : acc + 2 + ack;
        if (r.err) exp_tc = (exp_tc == 8'hFF) ? exp_tc : exp_tc + 8'd1;
        r.tc = exp_tc;
        rsp_q.push_back(r);
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int ack, input logic [31:0] rd);
        @(negedge mem_clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle: got req_ready_o=%b, want 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = wd;
        @(posedge mem_clk);
        #1;
        req_valid = 1'b0;
        expect_txn(wr, addr, wd, ack, rd, cyc);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < budget) begin
            @(negedge mem_clk);
            n++;
        end
        checks++;
        if (rsp_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL txn_timeout: %0d responses and %0d strobes outstanding, want 0", rsp_q.size(), bus_q.size());
            rsp_q.delete();
            bus_q.delete();
        end
    endtask

    task automatic test_reset();
        cpu_reset = 1'b1;
        repeat (3) @(negedge mem_clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_data, timeout_count, mem_valid, mem_read, mem_write} !== '0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b rsp=%b/%b/%h tc=%0d mem=%b%b%b/%h/%h, want all 0",
                     req_ready, rsp_valid, rsp_error, rsp_data, timeout_count, mem_valid, mem_read, mem_write, mem_addr, mem_wdata);
        end
        cpu_reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, want 1", req_ready);
        end
    endtask

    task automatic test_read();
        do_req(1'b0, 32'h8000_0088, 32'h0, 0, 32'h0000_00A5);
        wait_done(40);
    endtask

    task automatic test_write();
        do_req(1'b1, 32'h8000_008C, 32'h0000_003C, 0, 32'h5A5A_5A5A);
        wait_done(40);
    endtask

    task automatic test_timeout();
        do_req(1'b0, 32'h9000_0000, 32'h0, -1, 32'h0);
        wait_done(40);
    endtask

    task automatic test_late_ack();
        do_req(1'b0, 32'h8000_0090, 32'h0, TMO - 1, 32'h1234_5678);
        wait_done(40);
    endtask

    task automatic test_stray_ack();
        int n0;
        n0 = rsp_cnt;
        @(negedge mem_clk);
        stray_ack = 1'b1;
        @(negedge mem_clk);
        stray_ack = 1'b0;
        repeat (6) @(negedge mem_clk);
        checks++;
        if (rsp_cnt !== n0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_ack: got %0d responses ready=%b, want 0 responses ready=1", rsp_cnt - n0, req_ready);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 299; i++) begin
            do_req(1'b0, 32'h9000_0000 + i, 32'h0, -1, 32'h0);
            wait_done(40);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        @(negedge mem_clk);
        for (int i = 0; i < 8; i++) begin
            rd = $urandom;
            req_valid = 1'b1;
            req_write = i[0];
            req_addr  = 32'h8000_0100 + 4 * i;
            req_data  = $urandom;
            @(posedge mem_clk);
            #1;
            expect_txn(req_write, req_addr, req_data, 0, rd, cyc);
            for (int j = 0; j < 3; j++) begin
                @(negedge mem_clk);
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_busy: got req_ready_o=%b in busy cycle %0d of txn %0d, want 0", req_ready, j, i);
                end
            end
            @(negedge mem_clk);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_return: got req_ready_o=%b after txn %0d, want 1", req_ready, i);
            end
        end
        req_valid = 1'b0;
        wait_done(40);
    endtask

    task automatic test_reset_mid();
        do_req(1'b0, 32'h9000_0004, 32'h0, -1, 32'h0);
        repeat (5) @(negedge mem_clk);
        #2;
        cpu_reset = 1'b1;
        rsp_q.delete();
        bus_q.delete();
        exp_tc = 8'd0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_data, timeout_count, mem_valid, mem_read, mem_write} !== '0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: got ready=%b rsp=%b/%b/%h tc=%0d mem=%b%b%b/%h/%h, want all 0",
                     req_ready, rsp_valid, rsp_error, rsp_data, timeout_count, mem_valid, mem_read, mem_write, mem_addr, mem_wdata);
        end
        repeat (2) @(negedge mem_clk);
        cpu_reset = 1'b0;
        do_req(1'b0, 32'h8000_0088, 32'h0, 0, 32'h0000_00C3);
        wait_done(40);
    endtask

    initial begin
        checks = 0; errors = 0; rsp_cnt = 0; exp_tc = 8'd0;
        cpu_reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_data = 32'h0; stray_ack = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_late_ack();
        test_stray_ack();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge mem_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/w0rm_mem_initiator.md
# w0rm_mem_initiator

Bus initiator for the W0RM peripheral memory bus. It accepts single load/store requests from the core over a valid/ready handshake and drives them onto the bus as one-cycle strobes. It waits for the responder's registered acknowledge and returns read data, or a timeout error, to the core. It sits between the CPU load/store stage and the memory-mapped peripherals (GPIO, timers, etc.), which already implement the responder side of this bus.

## Interface
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width
- TIMEOUT_CYCLES, 16, WAIT cycles before a transaction is declared failed; legal range 1..255
- mem_clk  in  1  sole clock, rising edge
- cpu_reset  in  1  asynchronous, active-high reset
- req_valid_i  in  1  core request present
- req_ready_o  out  1  block can accept a request this cycle
- req_write_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_WIDTH  request address
- req_data_i  in  DATA_WIDTH  store data
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_data_o  out  DATA_WIDTH  load data; 0 for stores and errors
- rsp_error_o  out  1  qualifies rsp_valid_o; 1 = timeout
- timeout_count_o  out  8  saturating count of timed-out transactions
- mem_valid_o  out  1  bus request strobe
- mem_read_o  out  1  read qualifier; only high with mem_valid_o
- mem_write_o  out  1  write qualifier; only high with mem_valid_o
- mem_addr_o  out  ADDR_WIDTH  latched address
- mem_data_o  out  DATA_WIDTH  latched store data
- mem_valid_i  in  1  responder acknowledge (OR of all peripheral valids)
- mem_data_i  in  DATA_WIDTH  responder read data

## Operation
- States:
  - IDLE: req_ready_o = 1. If req_valid_i is high at an edge, latch write/addr/data, clear the timer, and go to ISSUE.
  - ISSUE: mem_valid_o = 1 for exactly one cycle. mem_read_o = !write, mem_write_o = write. Next state is WAIT.
  - WAIT:
    - If mem_valid_i: capture mem_data_i into rsp_data_o (load) or 0 (store), set rsp_error_o = 0, go to DONE.
    - Else if timer == TIMEOUT_CYCLES-1: rsp_data_o = 0, rsp_error_o = 1, increment timeout_count_o (saturate at 255), go to DONE.
    - Else increment the timer.
  - DONE: rsp_valid_o = 1 for one cycle, then go to IDLE.
- req_ready_o is low in ISSUE, WAIT and DONE. Requests presented then are not accepted; the core holds them.
- mem_valid_i is ignored outside WAIT, including in the ISSUE cycle. Stray acks are dropped.
- mem_valid_i and timer expiry in the same WAIT cycle: the ack wins, error = 0, timeout_count_o unchanged.
- mem_addr_o and mem_data_o hold the latched values until the next accept; they change only on an IDLE accept.
- rsp_data_o and rsp_error_o hold their last values until the next DONE. Only rsp_valid_o is a strobe.
- Timer width: enough bits to count to 255.

## Timing
- Reset values: state IDLE; all mem_* outputs 0; rsp_valid_o, rsp_error_o and rsp_data_o 0; timeout_count_o 0; req_ready_o 0 while cpu_reset is high, 1 in the first cycle after release.
- Reset asserted mid-transaction aborts immediately. No response is generated and timeout_count_o clears.
- Best-case latency with an ack in the first WAIT cycle:
  - request accepted at edge N;
  - mem_valid_o high in cycle N+1;
  - mem_valid_i high in N+2;
  - rsp_valid_o high in N+3;
  - req_ready_o high again in N+4.
- Back-to-back throughput: one transaction per 4 cycles minimum.
- Timeout: rsp_valid_o asserts TIMEOUT_CYCLES+2 cycles after the accept edge when no ack arrives.
- All outputs are registered except req_ready_o, which is decoded from state.

## Test plan
- Read to GPIO IDR at 0x80000088, responder returns 0x000000A5 one cycle after the strobe → mem_valid_o/mem_read_o high for exactly 1 cycle; rsp_valid_o 3 cycles after accept with rsp_data_o = 0xA5 and rsp_error_o = 0.
- Write 0x0000003C to 0x8000008C → mem_write_o high with mem_data_o = 0x3C for 1 cycle; rsp_valid_o 3 cycles after accept, rsp_data_o = 0, rsp_error_o = 0.
- Read to unmapped 0x90000000, no ack, TIMEOUT_CYCLES = 16 → rsp_valid_o 18 cycles after accept, rsp_error_o = 1, rsp_data_o = 0, timeout_count_o = 1. Repeat 300 times → timeout_count_o saturates at 255.
- Ack on the final WAIT cycle (cycle 16) → rsp_error_o = 0 with data captured; timeout_count_o unchanged. Stray mem_valid_i pulse in IDLE → no response generated.
- req_valid_i held high continuously with alternating reads and writes → exactly one accept per 4 cycles, req_ready_o low during ISSUE, WAIT and DONE, no dropped or duplicated strobes.
- cpu_reset pulsed during WAIT → all outputs 0 asynchronously; no rsp_valid_o; next request after release completes normally.
